// File: rtl/smi_mdio_master.sv
// smi_mdio_master: IEEE 802.3 Clause 22 MDC/MDIO station-management master
module smi_mdio_master #(
  parameter int MDC_DIV      = 25,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_125,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdout,
  output logic        mdout_en,
  input  logic        mdin
);
  localparam int DW = $clog2(MDC_DIV);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div;
  logic [5:0] bit_cnt, bit_last;
  logic [31:0] sr;
  logic [15:0] rx;
  logic rd, ack_err, tick, rise, fall, last;
  always_comb begin
    tick = div == DW'(MDC_DIV - 1);
    rise = tick && !mdc;
    fall = tick && mdc;
    bit_last = state == PREAMBLE ? 6'(PREAMBLE_LEN - 1) : state == HEADER ? 6'd13 : state == TA ? 6'd1 : 6'd15;
    last = bit_cnt == bit_last;
    state_nx = state == PREAMBLE ? HEADER : state == HEADER ? TA : state == TA ? DATA : DONE;
  end
  always_ff @(posedge clk_125 or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      sr <= '0;
      rx <= '0;
      rd <= 1'b0;
      ack_err <= 1'b0;
      mdc <= 1'b0;
      mdout <= 1'b1;
      mdout_en <= 1'b0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid) begin
          state <= PREAMBLE_LEN == 0 ? HEADER : PREAMBLE;
          sr <= {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_write ? cmd_wdata : 16'h0000};
          rd <= !cmd_write;
          div <= '0;
          bit_cnt <= '0;
          mdout <= PREAMBLE_LEN != 0;
          mdout_en <= 1'b1;
          cmd_ready <= 1'b0;
          busy <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
        cmd_ready <= 1'b1;
        busy <= 1'b0;
      end else begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) mdc <= !mdc;
        if (rise && rd && state == TA && bit_cnt == 6'd1) ack_err <= mdin;
        if (rise && rd && state == DATA) rx <= {rx[14:0], mdin};
        if (fall) begin
          bit_cnt <= last ? '0 : bit_cnt + 1'b1;
          if (last) state <= state_nx;
          if (state != PREAMBLE) sr <= sr << 1;
          mdout <= state == PREAMBLE ? (last ? sr[31] : 1'b1) : (state == DATA && last) ? 1'b1 : sr[30];
          if (state == HEADER && last && rd) mdout_en <= 1'b0;
          if (state == DATA && last) begin
            mdout_en <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err <= rd && ack_err;
            if (rd) rsp_rdata <= rx;
          end
        end
      end
    end
endmodule

// File: doc/smi_mdio_master.md
Name: smi_mdio_master

Overview:
- IEEE 802.3 Clause 22 station-management master. It generates MDC and serialises MDIO read/write frames to a PHY or to the SGMII PCS management register block.
- A simple command/response handshake lets a local controller (CPU bridge or init sequencer) access 16-bit PHY registers.
- Instantiated at the top level beside the SGMII channel. Its mdout/mdout_en/mdin drive the shared tri-state MDIO pin.

Parameters:
MDC_DIV, 25, clk_125 cycles per MDC half-period; legal range ≥2; 25 gives 2.5 MHz MDC.
PREAMBLE_LEN, 32, number of preamble '1' bits per frame; legal range 0..32.

Ports:
clk_125  input  1  single system clock; all logic is synchronous to its rising edge
rst_n  input  1  asynchronous reset, active low
cmd_valid  input  1  command request
cmd_ready  output  1  high in IDLE; a command is accepted on cmd_valid&cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_phy_addr  input  5  PHYAD (port_id of the target)
cmd_reg_addr  input  5  REGAD
cmd_wdata  input  16  write data
rsp_valid  output  1  one-cycle pulse at transaction end
rsp_rdata  output  16  read data; held until the next rsp_valid
rsp_err  output  1  read turnaround not acknowledged (TA bit 2 sampled as 1)
busy  output  1  high from acceptance until the rsp_valid cycle, inclusive
mdc  output  1  management clock
mdout  output  1  MDIO output data
mdout_en  output  1  MDIO output enable; top level drives the pin when high
mdin  input  1  MDIO pin input; top level has pull-up

Behaviour:
- Reset values (asynchronous, immediate):
  - mdc=0, mdout=1, mdout_en=0
  - cmd_ready=1, busy=0
  - rsp_valid=0, rsp_rdata=16'h0000, rsp_err=0
  - state=IDLE, divider=0, bit counter=0
- Reset during a frame aborts it. No rsp_valid is produced for the aborted frame.
- Frame, transmitted MSB first:
  - PREAMBLE_LEN × '1'
  - ST=01
  - OP: 01 for write, 10 for read
  - PHYAD[4:0], REGAD[4:0]
  - TA: write drives '10'; read releases the bus
  - DATA[15:0]
  - Total N = PREAMBLE_LEN+32 bits.
- Accept (IDLE, cmd_valid=1):
  - latch the fields into a 32-bit shift register
  - cmd_ready=0, busy=1 from the next cycle
  - mdout_en=1, mdout = first bit
  - divider cleared
- Each bit = MDC_DIV clocks with mdc low, then MDC_DIV clocks with mdc high.
  - mdc toggles when the divider reaches MDC_DIV-1; the divider then wraps to 0.
  - mdout changes only in the cycle mdc falls, so it is stable across each rising edge for the target.
- States:
  - IDLE → PREAMBLE on accept (→ HEADER directly if PREAMBLE_LEN=0)
  - PREAMBLE → HEADER after PREAMBLE_LEN bits
  - HEADER (14 bits: ST, OP, PHYAD, REGAD) → TA
  - TA (2 bits) → DATA
  - DATA (16 bits) → DONE
  - DONE → IDLE after one cycle
- Read, TA:
  - mdout_en=0 from the falling edge starting TA bit 1; it stays 0 through DATA.
  - mdin is sampled on the clk_125 cycle where mdc rises in TA bit 2. A sampled '1' sets rsp_err.
- Read, DATA: mdin sampled on each mdc rising-edge cycle and shifted into rsp_rdata MSB first.
- Read ack failure: when rsp_err=1, data is still shifted. With the pull-up this yields 16'hFFFF.
- Write:
  - mdout_en=1 through the last DATA bit
  - rsp_rdata unchanged, rsp_err=0
- End of frame:
  - After the high phase of the last bit, mdc falls and mdout_en=0, mdout=1.
  - DONE asserts rsp_valid for exactly one cycle, then returns to IDLE with cmd_ready=1.
- Latency: rsp_valid occurs 2·MDC_DIV·N cycles after the accept cycle (3200 at defaults).
- Next accept is possible the cycle after rsp_valid. Back-to-back frames are separated by ≥1 clk_125 cycle with mdc low.
- cmd_valid while busy is ignored; no queueing. The command fields need only be valid in the accept cycle.

Test Plan:
- Write PHY=5'h01, REG=5'h00, data=16'h1140 (defaults) → mdout shows 32×1, then 01 01 00001 00000 10 0001000101000000; mdout_en=1 throughout; rsp_valid 3200 cycles after accept; rsp_err=0.
- Read PHY=1, REG=5'h01; bus model drives TA2=0 and data 16'h0169 on rising edges → mdout_en drops at the TA1 falling edge; rsp_rdata=16'h0169; rsp_err=0.
- Read with no responder (mdin=1 constant) → rsp_err=1, rsp_rdata=16'hFFFF, rsp_valid still at 3200 cycles.
- Back-to-back write then read with cmd_valid held high → second accept the cycle after the first rsp_valid; mdc low between frames; a cmd_valid pulse mid-frame is ignored.
- rst_n asserted at bit 40 of a read → same cycle: mdc=0, mdout_en=0, busy=0; no rsp_valid; a following command completes normally.
- PREAMBLE_LEN=0, MDC_DIV=2, read → frame 32 bits, rsp_valid 128 cycles after accept, correct data capture.
